// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data RAM between several cores.
// Each grant runs a fixed four-cycle IDLE/ACCESS/RESP/DONE sequence with registered outputs.
module dmem_arbiter #(
    parameter int unsigned PortCount = 2,
    parameter int unsigned MemWidth  = 12,
    parameter int unsigned AddrWidth = 12
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [PortCount-1:0]           req_i,
    input  logic [PortCount-1:0]           we_i,
    input  logic [PortCount*AddrWidth-1:0] addr_i,
    input  logic [PortCount*MemWidth-1:0]  wdata_i,
    output logic [PortCount-1:0]           gnt_o,
    output logic [PortCount-1:0]           ack_o,
    output logic [MemWidth-1:0]            rdata_o,
    output logic                           busy_o,
    output logic [AddrWidth-1:0]           mem_address_o,
    output logic [MemWidth-1:0]            mem_datain_o,
    output logic                           mem_write_o,
    input  logic [MemWidth-1:0]            mem_dataout_i
);

    localparam int unsigned IdxWidth = (PortCount > 1) ? $clog2(PortCount) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [IdxWidth-1:0]    last_q, last_d;
    logic                   we_q, we_d;
    logic [PortCount-1:0]   gnt_q, gnt_d;
    logic [PortCount-1:0]   ack_q, ack_d;
    logic [MemWidth-1:0]    rdata_q, rdata_d;
    logic                   busy_q, busy_d;
    logic [AddrWidth-1:0]   mem_address_q, mem_address_d;
    logic [MemWidth-1:0]    mem_datain_q, mem_datain_d;
    logic                   mem_write_q, mem_write_d;

    logic                   win_valid;
    logic [IdxWidth-1:0]    win_idx;
    logic [IdxWidth-1:0]    cand;

    // Search starts one past the last winner and wraps, so the previous winner is checked last.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= PortCount; k++) begin
            cand = IdxWidth'((32'(last_q) + k) % PortCount);
            if (!win_valid && req_i[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        we_d          = we_q;
        gnt_d         = gnt_q;
        ack_d         = '0;
        rdata_d       = rdata_q;
        busy_d        = busy_q;
        mem_address_d = mem_address_q;
        mem_datain_d  = mem_datain_q;
        mem_write_d   = mem_write_q;

        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    state_d       = StAccess;
                    last_d        = win_idx;
                    gnt_d         = PortCount'(1) << win_idx;
                    busy_d        = 1'b1;
                    we_d          = we_i[win_idx];
                    mem_write_d   = we_i[win_idx];
                    mem_address_d = addr_i[win_idx*AddrWidth +: AddrWidth];
                    mem_datain_d  = wdata_i[win_idx*MemWidth +: MemWidth];
                end
            end
            StAccess: begin
                state_d     = StResp;
                mem_write_d = 1'b0;
            end
            StResp: begin
                state_d = StDone;
                ack_d   = gnt_q;
                // RAM q reflects the ACCESS-cycle address during this cycle.
                if (!we_q) begin
                    rdata_d = mem_dataout_i;
                end
            end
            StDone: begin
                state_d = StIdle;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            last_q        <= IdxWidth'(PortCount - 1);
            we_q          <= 1'b0;
            gnt_q         <= '0;
            ack_q         <= '0;
            rdata_q       <= '0;
            busy_q        <= 1'b0;
            mem_address_q <= '0;
            mem_datain_q  <= '0;
            mem_write_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            we_q          <= we_d;
            gnt_q         <= gnt_d;
            ack_q         <= ack_d;
            rdata_q       <= rdata_d;
            busy_q        <= busy_d;
            mem_address_q <= mem_address_d;
            mem_datain_q  <= mem_datain_d;
            mem_write_q   <= mem_write_d;
        end
    end

    assign gnt_o         = gnt_q;
    assign ack_o         = ack_q;
    assign rdata_o       = rdata_q;
    assign busy_o        = busy_q;
    assign mem_address_o = mem_address_q;
    assign mem_datain_o  = mem_datain_q;
    assign mem_write_o   = mem_write_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a 2-port instance backed by a RAM model and a 4-port
// instance used for wrap-around arbitration.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 2-port instance
    logic [1:0]  req, we, gnt, ack;
    logic [23:0] addr, wdata;
    logic [11:0] rdata, mem_address, mem_datain, mem_dataout;
    logic        busy, mem_write;

    // 4-port instance
    logic [3:0]  req4, we4, gnt4, ack4;
    logic [47:0] addr4, wdata4;
    logic [11:0] rdata4, mem_address4, mem_datain4, mem_dataout4;
    logic        busy4, mem_write4;

    logic [11:0] mem [0:4095];

    int n_vec = 0;
    int n_err = 0;

    dmem_arbiter #(.PortCount(2), .MemWidth(12), .AddrWidth(12)) u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req),
        .we_i          (we),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .gnt_o         (gnt),
        .ack_o         (ack),
        .rdata_o       (rdata),
        .busy_o        (busy),
        .mem_address_o (mem_address),
        .mem_datain_o  (mem_datain),
        .mem_write_o   (mem_write),
        .mem_dataout_i (mem_dataout)
    );

    dmem_arbiter #(.PortCount(4), .MemWidth(12), .AddrWidth(12)) u_dut4 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req4),
        .we_i          (we4),
        .addr_i        (addr4),
        .wdata_i       (wdata4),
        .gnt_o         (gnt4),
        .ack_o         (ack4),
        .rdata_o       (rdata4),
        .busy_o        (busy4),
        .mem_address_o (mem_address4),
        .mem_datain_o  (mem_datain4),
        .mem_write_o   (mem_write4),
        .mem_dataout_i (mem_dataout4)
    );

    // Single-port synchronous RAM: q is the word at last cycle's address.
    always @(posedge clk) begin
        if (mem_write) mem[mem_address] <= mem_datain;
        mem_dataout <= mem[mem_address];
    end

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [11:0] a0;
        logic [11:0] a1;
        logic [11:0] w0;
        logic [11:0] w1;
        logic [1:0]  gnt;
        logic        mw;
        logic [11:0] maddr;
        logic [11:0] mdin;
        logic [11:0] rdata;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies one request during IDLE and checks ACCESS, RESP, DONE and the following IDLE.
    task automatic run_vec(input vec_t v, input bit hold);
        req   = v.req;
        we    = v.we;
        addr  = {v.a1, v.a0};
        wdata = {v.w1, v.w0};
        @(posedge clk); #1;
        chk("gnt", 32'(gnt), 32'(v.gnt));
        chk("busy", 32'(busy), 32'd1);
        chk("mem_write_access", 32'(mem_write), 32'(v.mw));
        chk("mem_address", 32'(mem_address), 32'(v.maddr));
        if (v.mw) chk("mem_datain", 32'(mem_datain), 32'(v.mdin));
        chk("ack_access", 32'(ack), 32'd0);
        @(posedge clk); #1;
        chk("mem_write_resp", 32'(mem_write), 32'd0);
        chk("ack_resp", 32'(ack), 32'd0);
        @(posedge clk); #1;
        chk("ack_done", 32'(ack), 32'(v.gnt));
        chk("rdata", 32'(rdata), 32'(v.rdata));
        if (!hold) req = 2'b00;
        @(posedge clk); #1;
        chk("gnt_idle", 32'(gnt), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("ack_idle", 32'(ack), 32'd0);
    endtask

    initial begin
        vec_t v;
        int   served0, served1;
        logic [3:0] exp4 [3];

        // req, we, a0, a1, w0, w1, gnt, mw, maddr, mdin, rdata
        tbl[0] = '{2'b11, 2'b11, 12'h010, 12'h002, 12'h123, 12'h777, 2'b01, 1'b1, 12'h010, 12'h123, 12'h000};
        tbl[1] = '{2'b10, 2'b10, 12'h000, 12'h040, 12'h000, 12'hABC, 2'b10, 1'b1, 12'h040, 12'hABC, 12'h000};
        tbl[2] = '{2'b10, 2'b00, 12'h000, 12'h040, 12'h000, 12'h000, 2'b10, 1'b0, 12'h040, 12'h000, 12'hABC};
        tbl[3] = '{2'b01, 2'b00, 12'h010, 12'h000, 12'h000, 12'h000, 2'b01, 1'b0, 12'h010, 12'h000, 12'h123};
        tbl[4] = '{2'b11, 2'b00, 12'h010, 12'h040, 12'h000, 12'h000, 2'b10, 1'b0, 12'h040, 12'h000, 12'hABC};
        tbl[5] = '{2'b11, 2'b00, 12'h010, 12'h040, 12'h000, 12'h000, 2'b01, 1'b0, 12'h010, 12'h000, 12'h123};
        tbl[6] = '{2'b11, 2'b11, 12'h020, 12'h030, 12'h555, 12'h666, 2'b10, 1'b1, 12'h030, 12'h666, 12'h123};
        tbl[7] = '{2'b11, 2'b11, 12'h020, 12'h030, 12'h555, 12'h666, 2'b01, 1'b1, 12'h020, 12'h555, 12'h123};
        tbl[8] = '{2'b11, 2'b00, 12'h030, 12'h020, 12'h000, 12'h000, 2'b10, 1'b0, 12'h020, 12'h000, 12'h555};
        tbl[9] = '{2'b11, 2'b00, 12'h030, 12'h020, 12'h000, 12'h000, 2'b01, 1'b0, 12'h030, 12'h000, 12'h666};

        rst_n = 1'b0;
        req = 2'b11; we = 2'b00; addr = '0; wdata = '0;
        req4 = 4'b0000; we4 = 4'b0000; addr4 = '0; wdata4 = '0; mem_dataout4 = 12'h5A5;

        // Reset held with requests pending: everything stays at reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        chk("rst_mem_datain", 32'(mem_datain), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(tbl[i], 1'b0);

        // Contention: both cores request continuously, grants alternate starting with core 1.
        served0 = 0;
        served1 = 0;
        v = '{2'b11, 2'b00, 12'h030, 12'h020, 12'h000, 12'h000, 2'b10, 1'b0, 12'h020, 12'h000, 12'h555};
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                v.gnt = 2'b10; v.maddr = 12'h020; v.rdata = 12'h555;
            end else begin
                v.gnt = 2'b01; v.maddr = 12'h030; v.rdata = 12'h666;
            end
            run_vec(v, 1'b1);
            if (v.gnt == 2'b01) served0++; else served1++;
        end
        chk("served_core0", 32'(served0), 32'd10);
        chk("served_core1", 32'(served1), 32'd10);
        req = 2'b00;
        @(posedge clk); #1;

        // Late input change after grant: in-flight transaction keeps the latched address.
        req = 2'b01; we = 2'b00; addr = {12'h000, 12'h010};
        @(posedge clk); #1;
        chk("late_gnt", 32'(gnt), 32'd1);
        chk("late_addr_access", 32'(mem_address), 32'h010);
        addr = {12'h000, 12'h020};
        req  = 2'b00;
        @(posedge clk); #1;
        chk("late_addr_resp", 32'(mem_address), 32'h010);
        @(posedge clk); #1;
        chk("late_ack", 32'(ack), 32'd1);
        chk("late_rdata", 32'(rdata), 32'h123);
        @(posedge clk); #1;

        // Reset during the ACCESS cycle of a store.
        req = 2'b10; we = 2'b10; addr = {12'h040, 12'h000}; wdata = {12'hFFF, 12'h000};
        @(posedge clk); #1;
        chk("mid_mem_write", 32'(mem_write), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_write", 32'(mem_write), 32'd0);
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        req = 2'b00; we = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mid_rst_ack", 32'(ack), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_ack", 32'(ack), 32'd0);
        chk("mem_word_kept", 32'(mem[12'h040]), 32'hABC);
        v = '{2'b01, 2'b00, 12'h040, 12'h000, 12'h000, 12'h000, 2'b01, 1'b0, 12'h040, 12'h000, 12'hABC};
        run_vec(v, 1'b0);

        // Wrap-around on the 4-port instance, last starts at 3.
        exp4[0] = 4'b0001;
        exp4[1] = 4'b1000;
        exp4[2] = 4'b0001;
        req4  = 4'b1001;
        addr4 = {12'h300, 12'h200, 12'h100, 12'h000};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("w4_gnt", 32'(gnt4), 32'(exp4[i]));
            chk("w4_addr", 32'(mem_address4), (exp4[i] == 4'b0001) ? 32'h000 : 32'h300);
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk("w4_ack", 32'(ack4), 32'(exp4[i]));
            chk("w4_rdata", 32'(rdata4), 32'h5A5);
            @(posedge clk); #1;
            chk("w4_busy_idle", 32'(busy4), 32'd0);
        end
        req4 = 4'b0000;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
